emisor_secuencia: RTL and testbench

//  Transmit end of the switch-code unlock interface: replays a stored N-digit code as a timed

---
 rtl/emisor_secuencia_pkg.sv | 20 ++
 rtl/digito_a_onehot.sv | 16 +
 rtl/emisor_secuencia.sv | 148 ++++++++++++++
 tb/tb_emisor_secuencia.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/emisor_secuencia_pkg.sv
// Shared definitions for the switch-code unlock interface (transmitter and checker).
// The state codes double as the values reported on the status bus.
package emisor_secuencia_pkg;

  localparam int SW_W    = 10;
  localparam int DIGIT_W = 4;
  localparam int ST_W    = 4;

  localparam logic [ST_W-1:0] ST_IDLE  = 4'd0;
  localparam logic [ST_W-1:0] ST_SEND  = 4'd1;
  localparam logic [ST_W-1:0] ST_GAP   = 4'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 4'd4;
  localparam logic [ST_W-1:0] ST_ERROR = 4'd5;

  typedef logic [SW_W-1:0]    sw_word_t;
  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t MAX_DIGIT = 4'd9;

endpackage

// File: rtl/digito_a_onehot.sv
// Combinational decimal digit to one-hot switch word converter.
// Digits above 9 give an all-zero word and a cleared valid flag.
module digito_a_onehot
  import emisor_secuencia_pkg::*;
(
  input  digit_t   digit_i,
  output sw_word_t onehot_o,
  output logic     valid_o
);

  always_comb begin
    valid_o  = (digit_i <= MAX_DIGIT);
    onehot_o = valid_o ? (sw_word_t'(1) << digit_i) : '0;
  end

endmodule

// File: rtl/emisor_secuencia.sv
// Replays a stored N-digit code as timed one-hot switch words separated by zero gap words.
// All outputs are registered; status_o is the state register itself.
module emisor_secuencia
  import emisor_secuencia_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1,
  parameter logic [DIGIT_W*N_DIGITS-1:0] DEFAULT_CODE = {4'd6, 4'd1, 4'd0, 4'd2},
  localparam int IDX_W = $clog2(N_DIGITS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          load_i,
  input  logic [DIGIT_W*N_DIGITS-1:0]   code_i,
  input  logic                          clear_i,
  output sw_word_t                      sw_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [IDX_W-1:0]              digit_idx_o,
  output logic [ST_W-1:0]               status_o
);

  localparam int CODE_W  = DIGIT_W * N_DIGITS;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  sw_word_t          sw_q, sw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  sw_word_t          digitWord [N_DIGITS];
  logic [N_DIGITS-1:0] digitValid;
  sw_word_t          selWord;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    digito_a_onehot u_digit (
      .digit_i  (code_q[DIGIT_W*g +: DIGIT_W]),
      .onehot_o (digitWord[g]),
      .valid_o  (digitValid[g])
    );
  end

  // Counter restarts on every transition, including the SEND->SEND digit step when there is no gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (load_i) begin
          code_d = code_i;
        end else if (start_i) begin
          state_d = (&digitValid) ? ST_SEND : ST_ERROR;
        end
      end
      ST_SEND: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
          end else if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEND;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE, ST_ERROR: begin
        if (clear_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output words are computed from the next state so they land in the same cycle as the state.
  always_comb begin
    selWord = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) selWord = digitWord[i];
    end
    sw_d   = (state_d == ST_SEND) ? selWord : '0;
    busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      code_q  <= DEFAULT_CODE;
      sw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sw_o        = sw_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign digit_idx_o = idx_q;
  assign status_o    = state_q;

endmodule

// File: tb/tb_emisor_secuencia.sv
// Directed bench for emisor_secuencia: default replay, error path, ignored strobes,
// async reset mid-send, load/start priority, and a hold-3/no-gap variant.
module tb_emisor_secuencia;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] codeIn = 16'h0;

  logic [9:0]  sw, sw6;
  logic        busy, done, busy6, done6;
  logic [2:0]  idx, idx6;
  logic [3:0]  status, status6;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  emisor_secuencia dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .load_i      (load),
    .code_i      (codeIn),
    .clear_i     (clear),
    .sw_o        (sw),
    .busy_o      (busy),
    .done_o      (done),
    .digit_idx_o (idx),
    .status_o    (status)
  );

  emisor_secuencia #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) dut6 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .load_i      (load),
    .code_i      (codeIn),
    .clear_i     (clear),
    .sw_o        (sw6),
    .busy_o      (busy6),
    .done_o      (done6),
    .digit_idx_o (idx6),
    .status_o    (status6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic l, input logic c, input logic [15:0] code);
    start  = s;
    load   = l;
    clear  = c;
    codeIn = code;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic runStart();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    stepClk();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
    stepClk();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " sw"},     sw,     10'h000);
    checkOutput({tag, " status"}, status, 4'd0);
    checkOutput({tag, " busy"},   busy,   1'b0);
    checkOutput({tag, " done"},   done,   1'b0);
    checkOutput({tag, " idx"},    idx,    3'd0);
  endtask

  // Called right after the edge that accepted start; walks four digit/gap pairs into DONE.
  task automatic checkStream(input string tag, input logic [9:0] d0, input logic [9:0] d1,
                             input logic [9:0] d2, input logic [9:0] d3, input bit disturb);
    logic [9:0] w [4];
    w = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s sw d%0d", tag, i),     sw,     w[i]);
      checkOutput($sformatf("%s status d%0d", tag, i), status, 4'd1);
      checkOutput($sformatf("%s idx d%0d", tag, i),    idx,    i);
      checkOutput($sformatf("%s busy d%0d", tag, i),   busy,   1'b1);
      if (disturb && i == 1) applyStimulus(1'b1, 1'b1, 1'b0, 16'h9999);
      stepClk();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput($sformatf("%s gap sw d%0d", tag, i),     sw,     10'h000);
      checkOutput($sformatf("%s gap status d%0d", tag, i), status, 4'd2);
      checkOutput($sformatf("%s gap idx d%0d", tag, i),    idx,    i);
      stepClk();
    end
    checkOutput({tag, " done status"}, status, 4'd4);
    checkOutput({tag, " done flag"},   done,   1'b1);
    checkOutput({tag, " done sw"},     sw,     10'h000);
    checkOutput({tag, " done idx"},    idx,    3'd3);
    checkOutput({tag, " done busy"},   busy,   1'b0);
  endtask

  initial begin
    logic [9:0] w6 [4];

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    #1 rst_n = 1'b0;
    #1;
    checkIdle("reset");
    checkOutput("reset status6", status6, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stepClk();
    checkIdle("post reset");

    // Default code 6,1,0,2 sent digit 0 first
    runStart();
    checkStream("t1", 10'h004, 10'h001, 10'h002, 10'h040, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    stepClk();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t1 sticky status", status, 4'd4);
    checkOutput("t1 sticky done",   done,   1'b1);
    doClear();
    checkIdle("t1 clear");

    // Invalid digit (12) -> ERROR, sticky until clear
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3C07);
    stepClk();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkIdle("t2 load");
    runStart();
    checkOutput("t2 status", status, 4'd5);
    checkOutput("t2 sw",     sw,     10'h000);
    checkOutput("t2 busy",   busy,   1'b0);
    checkOutput("t2 done",   done,   1'b0);
    stepClk();
    checkOutput("t2 sticky status", status, 4'd5);
    doClear();
    checkIdle("t2 clear");

    // Strobes while busy are ignored; code register untouched
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h6102);
    stepClk();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    runStart();
    checkStream("t3", 10'h004, 10'h001, 10'h002, 10'h040, 1'b1);
    doClear();
    runStart();
    checkStream("t3 replay", 10'h004, 10'h001, 10'h002, 10'h040, 1'b0);
    doClear();

    // load wins over start in the same cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h9876);
    stepClk();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkIdle("t5 same cycle");
    runStart();
    checkStream("t5", 10'h040, 10'h080, 10'h100, 10'h200, 1'b0);
    doClear();

    // Asynchronous reset in the middle of SEND restores the default code
    runStart();
    checkOutput("t4 first sw", sw, 10'h040);
    stepClk();
    stepClk();
    checkOutput("t4 mid sw",     sw,     10'h080);
    checkOutput("t4 mid status", status, 4'd1);
    #1 rst_n = 1'b0;
    #1;
    checkIdle("t4 async");
    #1 rst_n = 1'b1;
    runStart();
    checkStream("t4 default", 10'h004, 10'h001, 10'h002, 10'h040, 1'b0);
    doClear();

    // HOLD_CYCLES=3, GAP_CYCLES=0 instance
    rst_n = 1'b0;
    #1;
    checkOutput("t6 reset status6", status6, 4'd0);
    rst_n = 1'b1;
    runStart();
    w6 = '{10'h004, 10'h001, 10'h002, 10'h040};
    for (int c = 0; c < 12; c++) begin
      checkOutput($sformatf("t6 sw6 c%0d", c),     sw6,     w6[c/3]);
      checkOutput($sformatf("t6 status6 c%0d", c), status6, 4'd1);
      stepClk();
    end
    checkOutput("t6 done status6", status6, 4'd4);
    checkOutput("t6 done6",        done6,   1'b1);
    checkOutput("t6 done sw6",     sw6,     10'h000);
    checkOutput("t6 done busy6",   busy6,   1'b0);
    checkOutput("t6 done idx6",    idx6,    3'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
